// File: rtl/isr_push_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : isr_push_ctrl_if
// Description : Decoder/ISR/RX-FIFO bundle for isr_push_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface isr_push_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
);
    logic              penable;
    logic              in_req;
    logic [4:0]        in_bits;
    logic              push_req;
    logic              push_block;
    logic              push_iffull;
    logic              autopush_en;
    logic [4:0]        push_thresh;
    logic [CNT_W-1:0]  isr_count;
    logic [DATA_W-1:0] isr_data;
    logic              rx_full;

    logic              isr_shift;
    logic              isr_clear;
    logic              rx_push;
    logic [DATA_W-1:0] rx_data;
    logic              stall;
    logic              done;
    logic              drop;
    logic [7:0]        drop_count;

    // Master is the decoder/ISR/FIFO side that presents requests and status.
    modport master (
        output penable, in_req, in_bits, push_req, push_block, push_iffull,
               autopush_en, push_thresh, isr_count, isr_data, rx_full,
        input  isr_shift, isr_clear, rx_push, rx_data, stall, done, drop,
               drop_count
    );

    modport slave (
        input  penable, in_req, in_bits, push_req, push_block, push_iffull,
               autopush_en, push_thresh, isr_count, isr_data, rx_full,
        output isr_shift, isr_clear, rx_push, rx_data, stall, done, drop,
               drop_count
    );
endinterface
`default_nettype wire

// File: rtl/isr_push_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : isr_push_ctrl
// Description : ISR shift/clear and RX FIFO push sequencing with autopush.
//               Optional saturating drop counter: define ISR_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module isr_push_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  wire logic        clk,
    input  wire logic        reset,
    isr_push_ctrl_if.slave   bus
);
    localparam logic [CNT_W:0] c_max = (CNT_W+1)'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_AUTO      = 2'd1,
        S_PUSH_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_active;
    logic [CNT_W-1:0] w_bits_val;
    logic [CNT_W-1:0] w_thr;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_after;
    logic             w_shift;
    logic             w_clear;
    logic             w_push;
    logic             w_stall;
    logic             w_done;
    logic             w_drop;

    // Reset gates the strobes so nothing escapes while the FSM is being aborted.
    assign w_active    = bus.penable & ~reset;
    assign w_bits_val  = (bus.in_bits == 5'd0)     ? c_max[CNT_W-1:0] : CNT_W'(bus.in_bits);
    assign w_thr       = (bus.push_thresh == 5'd0) ? c_max[CNT_W-1:0] : CNT_W'(bus.push_thresh);
    assign w_sum       = {1'b0, bus.isr_count} + {1'b0, w_bits_val};
    assign w_cnt_after = (w_sum > c_max) ? c_max[CNT_W-1:0] : w_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (w_active) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_shift = 1'b0;
        w_clear = 1'b0;
        w_push  = 1'b0;
        w_stall = 1'b0;
        w_done  = 1'b0;
        w_drop  = 1'b0;
        if (w_active) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_req) begin
                        w_shift = 1'b1;
                        if (bus.autopush_en && (w_cnt_after >= w_thr)) begin
                            w_stall = 1'b1;
                            w_next  = S_AUTO;
                        end else begin
                            w_done = 1'b1;
                        end
                    end else if (bus.push_req) begin
                        if (bus.push_iffull && (bus.isr_count < w_thr)) begin
                            w_done = 1'b1;
                        end else if (!bus.rx_full) begin
                            w_push  = 1'b1;
                            w_clear = 1'b1;
                            w_done  = 1'b1;
                        end else if (bus.push_block) begin
                            w_stall = 1'b1;
                            w_next  = S_PUSH_WAIT;
                        end else begin
                            w_clear = 1'b1;
                            w_drop  = 1'b1;
                            w_done  = 1'b1;
                        end
                    end
                end
                S_AUTO, S_PUSH_WAIT: begin
                    if (!bus.rx_full) begin
                        w_push  = 1'b1;
                        w_clear = 1'b1;
                        w_done  = 1'b1;
                        w_next  = S_IDLE;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign bus.isr_shift = w_shift;
    assign bus.isr_clear = w_clear;
    assign bus.rx_push   = w_push;
    assign bus.stall     = w_stall;
    assign bus.done      = w_done;
    assign bus.drop      = w_drop;
    // FIFO write data is a straight pass-through of the ISR contents.
    assign bus.rx_data   = bus.isr_data;

`ifdef ISR_DROP_CNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= 8'd0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign bus.drop_count = r_drop_count;
`else
    assign bus.drop_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_isr_push_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_isr_push_ctrl
// Description : Directed and random checks of isr_push_ctrl against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isr_push_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: whether an instruction is waiting for FIFO space, drops seen, ISR fill.
    bit   m_wait;
    int   m_drops;
    int   m_cnt;

    always #5 clk = ~clk;

    isr_push_ctrl_if bus ();

    isr_push_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic int exp_drop_count();
`ifdef ISR_DROP_CNT_EN
        return (m_drops > 255) ? 255 : m_drops;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.isr_shift, bus.isr_clear, bus.rx_push, bus.stall, bus.done, bus.drop};
    endfunction

    // Strobe vector order: shift, clear, push, stall, done, drop.
    task automatic step(input string tag, input bit use_want = 1'b0,
                        input logic [5:0] want = 6'd0);
        logic [5:0] e;
        bit         nxt_wait;
        bit         act;
        int         bits, thr, after;
        @(negedge clk);
        e        = 6'd0;
        nxt_wait = m_wait;
        act      = bus.penable && !reset;
        bits     = (bus.in_bits == 0) ? 32 : int'(bus.in_bits);
        thr      = (bus.push_thresh == 0) ? 32 : int'(bus.push_thresh);
        after    = int'(bus.isr_count) + bits;
        if (after > 32) after = 32;
        if (act) begin
            if (m_wait) begin
                if (!bus.rx_full) begin e = 6'b011010; nxt_wait = 1'b0; end
                else e = 6'b000100;
            end else if (bus.in_req) begin
                if (bus.autopush_en && after >= thr) begin e = 6'b100100; nxt_wait = 1'b1; end
                else e = 6'b100010;
            end else if (bus.push_req) begin
                if (bus.push_iffull && int'(bus.isr_count) < thr) e = 6'b000010;
                else if (!bus.rx_full) e = 6'b011010;
                else if (bus.push_block) begin e = 6'b000100; nxt_wait = 1'b1; end
                else e = 6'b010011;
            end
        end
        chk({tag, "_strobes"}, 32'(strobes()), 32'(e));
        if (use_want) chk({tag, "_plan"}, 32'(strobes()), 32'(want));
        chk({tag, "_rx_data"}, bus.rx_data, bus.isr_data);
        chk({tag, "_drop_count"}, 32'(bus.drop_count), 32'(exp_drop_count()));
        @(posedge clk);
        if (act) begin
            m_wait = nxt_wait;
            if (e[0]) m_drops++;
            if (e[4]) m_cnt = 0;
            else if (e[5]) m_cnt = after;
        end
        #1;
    endtask

    task automatic model_reset();
        m_wait  = 1'b0;
        m_drops = 0;
        m_cnt   = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_strobes", 32'(strobes()), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.penable     = 1'b1;
        bus.in_req      = 1'b0;
        bus.in_bits     = 5'd0;
        bus.push_req    = 1'b0;
        bus.push_block  = 1'b0;
        bus.push_iffull = 1'b0;
        bus.autopush_en = 1'b0;
        bus.push_thresh = 5'd0;
        bus.isr_count   = 6'd0;
        bus.isr_data    = 32'hA5A5_0001;
        bus.rx_full     = 1'b0;
        model_reset();
        #1;
        chk("reset_strobes", 32'(strobes()), 32'd0);
        chk("reset_drop_count", 32'(bus.drop_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("idle", 1'b1, 6'b000000);

        // Autopush with FIFO space: shift+stall, then push.
        bus.autopush_en = 1'b1; bus.push_thresh = 5'd8; bus.isr_count = 6'd0;
        bus.in_req = 1'b1; bus.in_bits = 5'd8;
        step("ap_in", 1'b1, 6'b100100);
        step("ap_push", 1'b1, 6'b011010);
        bus.in_req = 1'b0;
        step("ap_idle", 1'b1, 6'b000000);

        // Autopush with FIFO full for three AUTO cycles.
        bus.in_req = 1'b1; bus.rx_full = 1'b1;
        step("apf_in", 1'b1, 6'b100100);
        for (int i = 0; i < 3; i++) step("apf_stall", 1'b1, 6'b000100);
        bus.rx_full = 1'b0;
        step("apf_push", 1'b1, 6'b011010);
        bus.in_req = 1'b0;
        step("apf_idle", 1'b1, 6'b000000);

        // Saturating count and a zero threshold meaning 32.
        bus.isr_count = 6'd32; bus.in_bits = 5'd5; bus.push_thresh = 5'd0; bus.in_req = 1'b1;
        step("sat_in", 1'b1, 6'b100100);
        step("sat_push", 1'b1, 6'b011010);

        // IN without autopush retires immediately.
        bus.autopush_en = 1'b0; bus.isr_count = 6'd4;
        step("in_plain", 1'b1, 6'b100010);
        bus.in_req = 1'b0;

        // PUSH iffull below threshold is a no-op retire.
        bus.push_req = 1'b1; bus.push_iffull = 1'b1; bus.push_thresh = 5'd16; bus.isr_count = 6'd12;
        step("iffull_low", 1'b1, 6'b000010);
        bus.isr_count = 6'd16;
        step("iffull_hit", 1'b1, 6'b011010);

        // Non-blocking PUSH to a full FIFO, enough times to saturate.
        bus.push_iffull = 1'b0; bus.push_block = 1'b0; bus.rx_full = 1'b1;
        for (int i = 0; i < 300; i++) step("drop", 1'b1, 6'b010011);
`ifdef ISR_DROP_CNT_EN
        chk("drop_sat", 32'(bus.drop_count), 32'd255);
`else
        chk("drop_tied", 32'(bus.drop_count), 32'd0);
`endif

        // Blocking PUSH aborted by a mid-cycle reset.
        bus.push_block = 1'b1;
        step("blk_enter", 1'b1, 6'b000100);
        step("blk_wait", 1'b1, 6'b000100);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("blk_rst_strobes", 32'(strobes()), 32'd0);
        chk("blk_rst_drop_count", 32'(bus.drop_count), 32'd0);
        bus.rx_full = 1'b0;
        #1;
        chk("blk_rst_nopush", 32'(strobes()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.push_req = 1'b0;
        step("blk_after", 1'b1, 6'b000000);

        // penable gating while in AUTO.
        bus.autopush_en = 1'b1; bus.push_thresh = 5'd4; bus.isr_count = 6'd0;
        bus.in_bits = 5'd4; bus.in_req = 1'b1;
        step("pen_in", 1'b1, 6'b100100);
        bus.penable = 1'b0;
        step("pen_off0", 1'b1, 6'b000000);
        step("pen_off1", 1'b1, 6'b000000);
        bus.penable = 1'b1;
        step("pen_push", 1'b1, 6'b011010);
        bus.in_req = 1'b0;

        // Random traffic with the ISR fill tracked by the model.
        m_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            bus.penable     = ($urandom_range(0, 9) != 0);
            bus.in_req      = ($urandom_range(0, 2) == 0);
            bus.push_req    = ($urandom_range(0, 2) == 0);
            bus.in_bits     = 5'($urandom);
            bus.push_thresh = 5'($urandom);
            bus.push_block  = 1'($urandom);
            bus.push_iffull = 1'($urandom);
            bus.autopush_en = 1'($urandom);
            bus.rx_full     = 1'($urandom);
            bus.isr_data    = $urandom;
            bus.isr_count   = 6'(m_cnt);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/isr_push_ctrl.md
Name: isr_push_ctrl

Overview:
- Sequences the ISR shift register and the RX FIFO write port for one state machine.
- Turns IN and PUSH instruction requests into ISR shift/clear strobes and FIFO push strobes.
- Applies autopush threshold and blocking rules, and reports stall and retire status back to the instruction decoder.
- Sits between the decoder, the ISR, and the RX FIFO.

Parameters:
- DATA_W, 32, ISR/FIFO data width; only 32 is supported.
- CNT_W, 6, width of the ISR bit count; holds 0..32.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active high.
- penable  in  1  state-machine clock enable; when low, nothing advances.
- in_req  in  1  IN instruction present this cycle.
- in_bits  in  5  IN bit count; 0 means 32.
- push_req  in  1  PUSH instruction present this cycle.
- push_block  in  1  PUSH block flag.
- push_iffull  in  1  PUSH iffull flag.
- autopush_en  in  1  autopush enable, from config.
- push_thresh  in  5  autopush/iffull threshold; 0 means 32.
- isr_count  in  6  current ISR shift count (0..32).
- isr_data  in  32  current ISR contents.
- rx_full  in  1  RX FIFO full.
- isr_shift  out  1  ISR do_shift strobe.
- isr_clear  out  1  ISR load strobe; ISR loads data 0 and count 0.
- rx_push  out  1  RX FIFO write strobe.
- rx_data  out  32  FIFO write data; equals isr_data.
- stall  out  1  current instruction not complete.
- done  out  1  instruction retires this cycle.
- drop  out  1  pulse on a non-blocking PUSH to a full FIFO.
- drop_count  out  8  saturating drop counter (optional feature).

Behaviour:
- Strobes and status outputs (isr_shift, isr_clear, rx_push, stall, done, drop) are combinational from state and inputs, qualified by penable. The ISR and FIFO therefore update on the same clk edge.
- rx_data = isr_data at all times.
- All outputs are 0 whenever penable=0. State and counters hold.
- Widths:
  - bits_val = (in_bits==0) ? 32 : in_bits.
  - thr = (push_thresh==0) ? 32 : push_thresh.
  - cnt_after = min(isr_count+bits_val, 32), computed at 7 bits then saturated.
- Reset (async) forces state IDLE and clears drop_count. All outputs are 0 during and after reset.
- Requests are sampled only in IDLE with penable=1.
  - in_req has priority; a simultaneous push_req is ignored.
  - While stalled, the decoder holds its request and flags; they are ignored outside IDLE.
- States: IDLE, AUTO, PUSH_WAIT.
- IDLE, in_req:
  - isr_shift=1.
  - If autopush_en and cnt_after>=thr: go to AUTO, stall=1.
  - Else: done=1, stay in IDLE.
- AUTO:
  - If rx_full=0: rx_push=1, isr_clear=1, done=1, go to IDLE.
  - Else: stall=1, hold.
- IDLE, push_req:
  - If push_iffull and isr_count<thr: done=1, no strobes.
  - Else if rx_full=0: rx_push=1, isr_clear=1, done=1.
  - Else if push_block: stall=1, go to PUSH_WAIT.
  - Else: isr_clear=1, drop=1, done=1; data is lost.
- PUSH_WAIT:
  - If rx_full=0: rx_push=1, isr_clear=1, done=1, go to IDLE.
  - Else: stall=1.
- Latency:
  - IN without autopush retires in 1 cycle.
  - IN with autopush retires in at least 2 cycles.
  - Non-blocked PUSH retires in 1 cycle.
- No request in IDLE: all outputs 0.
- Boundary cases:
  - isr_count=32 with in_bits=5 gives cnt_after=32.
  - thr=32 with cnt_after=32 triggers autopush.
  - rx_full dropping in the same cycle the state is entered takes effect the next cycle; the FSM samples rx_full only while in AUTO or PUSH_WAIT.
  - Reset asserted in AUTO or PUSH_WAIT aborts with no push.

Optional Feature:
- Macro: ISR_DROP_CNT_EN.
- Defined: drop_count increments on each drop pulse and saturates at 255. Cleared only by reset.
- Undefined: drop_count is tied to 0 and no counter register exists. The drop pulse is still generated.

Test Plan:
- Autopush, FIFO not full: autopush_en=1, push_thresh=8, isr_count=0; IN in_bits=8 with rx_full=0 -> cycle 1: isr_shift=1, stall=1; cycle 2: rx_push=1, isr_clear=1, done=1.
- Autopush, FIFO full: same as above but rx_full=1 for 3 cycles, then 0 -> stall=1 for 3 AUTO cycles, then rx_push, then IDLE.
- PUSH iffull below threshold: push_iffull=1, thr=16, isr_count=12 -> done=1, no rx_push or isr_clear.
- Non-blocking PUSH to full FIFO: push_block=0, rx_full=1, repeated 300 times -> each gives isr_clear=1, drop=1, done=1; with the macro defined, drop_count=255.
- Blocking PUSH with reset: push_block=1, rx_full=1, reset asserted mid-PUSH_WAIT -> all outputs 0 immediately; after release, IDLE with no push.
- penable gating: penable=0 for 2 cycles during AUTO with rx_full=0 -> no strobes; push occurs on the first cycle with penable=1.
